// File: rtl/alu_addsub_dispatch.sv
// alu_addsub_dispatch: in-order tagged request dispatch to a multi-cycle add/sub ALU. Issue latency 1 cycle
// (0 with ALU_DISPATCH_BYPASS_EN); req_ready = request FIFO not full; rsp held until rsp_ready; credits bound in-flight ops.

// fifo: generic show-ahead FIFO, write visible at head next cycle; push accepted when not full or when popping.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_rdy,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;
    logic             w_wr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_rd     = i_rd_rdy & ~o_empty;
    assign w_wr     = i_wr_vld & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module alu_addsub_dispatch #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int FLAGS_WIDTH  = 4,
    parameter int TAG_WIDTH    = 4,
    parameter int REQ_DEPTH    = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPCODE_WIDTH-1:0] req_opcode,
    input  logic [DATA_WIDTH-1:0]   req_a,
    input  logic [DATA_WIDTH-1:0]   req_b,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    output logic                    alu_data_valid,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [DATA_WIDTH-1:0]   alu_data_a,
    output logic [DATA_WIDTH-1:0]   alu_data_b,
    input  logic                    alu_result_valid,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [FLAGS_WIDTH-1:0]  alu_result_flags,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic [FLAGS_WIDTH-1:0]  rsp_flags,
    output logic [TAG_WIDTH-1:0]    rsp_tag,
    output logic                    err_spurious
);
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [DATA_WIDTH-1:0]   a;
        logic [DATA_WIDTH-1:0]   b;
        logic [TAG_WIDTH-1:0]    tag;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  result;
        logic [FLAGS_WIDTH-1:0] flags;
        logic [TAG_WIDTH-1:0]   tag;
    } rsp_t;

    localparam int CRW = $clog2(MAX_INFLIGHT + 1);

    req_t                    w_req_in;
    req_t                    w_req_head;
    req_t                    w_issue_dat;
    rsp_t                    w_cap_dat;
    rsp_t                    w_rsp_head;
    logic                    w_req_empty;
    logic                    w_req_full;
    logic                    w_req_fire;
    logic                    w_credit_ok;
    logic                    w_direct;
    logic                    w_fifo_pop;
    logic                    w_fifo_push;
    logic                    w_issue;
    logic                    w_capture;
    logic                    w_rsp_pop;
    logic                    w_rsp_empty;
    logic                    w_rsp_full;
    logic                    w_tag_empty;
    logic                    w_tag_full;
    logic [TAG_WIDTH-1:0]    w_tag_head;
    logic                    w_unused;
    logic [CRW-1:0]          r_credits;
    logic                    r_alu_vld;
    logic [OPCODE_WIDTH-1:0] r_alu_opcode;
    logic [DATA_WIDTH-1:0]   r_alu_a;
    logic [DATA_WIDTH-1:0]   r_alu_b;
    logic                    r_err;

    assign w_req_in    = {req_opcode, req_a, req_b, req_tag};
    assign req_ready   = rst_n & ~w_req_full;
    assign w_req_fire  = req_valid & req_ready;
    assign w_credit_ok = (r_credits < CRW'(MAX_INFLIGHT));

    // An accepted request skips the FIFO when it is empty, so an idle block issues one cycle after accept.
`ifdef ALU_DISPATCH_BYPASS_EN
    assign w_direct    = w_req_fire & w_req_empty & w_credit_ok & ~r_alu_vld;
`else
    assign w_direct    = w_req_fire & w_req_empty & w_credit_ok;
`endif
    assign w_fifo_pop  = ~w_req_empty & w_credit_ok;
    assign w_fifo_push = w_req_fire & ~w_direct;
    assign w_issue     = w_direct | w_fifo_pop;
    assign w_issue_dat = w_direct ? w_req_in : w_req_head;

    fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (w_fifo_push),
        .i_wr_dat (w_req_in),
        .i_rd_rdy (w_fifo_pop),
        .o_rd_dat (w_req_head),
        .o_empty  (w_req_empty),
        .o_full   (w_req_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_vld    <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
        end else begin
`ifdef ALU_DISPATCH_BYPASS_EN
            r_alu_vld <= w_fifo_pop;
`else
            r_alu_vld <= w_issue;
`endif
            if (w_issue) begin
                r_alu_opcode <= w_issue_dat.opcode;
                r_alu_a      <= w_issue_dat.a;
                r_alu_b      <= w_issue_dat.b;
            end
        end
    end

`ifdef ALU_DISPATCH_BYPASS_EN
    assign alu_data_valid = r_alu_vld | w_direct;
    assign alu_opcode     = w_direct ? req_opcode : r_alu_opcode;
    assign alu_data_a     = w_direct ? req_a : r_alu_a;
    assign alu_data_b     = w_direct ? req_b : r_alu_b;
`else
    assign alu_data_valid = r_alu_vld;
    assign alu_opcode     = r_alu_opcode;
    assign alu_data_a     = r_alu_a;
    assign alu_data_b     = r_alu_b;
`endif

    // Tags ride alongside the ALU pipeline; the ALU returns results in issue order.
    fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (w_issue),
        .i_wr_dat (w_issue_dat.tag),
        .i_rd_rdy (w_capture),
        .o_rd_dat (w_tag_head),
        .o_empty  (w_tag_empty),
        .o_full   (w_tag_full)
    );

    assign w_capture = alu_result_valid & ~w_tag_empty;
    assign w_cap_dat = {alu_result, alu_result_flags, w_tag_head};
    assign w_rsp_pop = rsp_valid & rsp_ready;

    fifo #(.WIDTH($bits(rsp_t)), .DEPTH(MAX_INFLIGHT)) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_vld (w_capture),
        .i_wr_dat (w_cap_dat),
        .i_rd_rdy (w_rsp_pop),
        .o_rd_dat (w_rsp_head),
        .o_empty  (w_rsp_empty),
        .o_full   (w_rsp_full)
    );

    // Full flags are implied by the credit count and never gate anything.
    assign w_unused = w_rsp_full | w_tag_full;

    assign rsp_valid  = ~w_rsp_empty;
    assign rsp_result = rsp_valid ? w_rsp_head.result : '0;
    assign rsp_flags  = rsp_valid ? w_rsp_head.flags : '0;
    assign rsp_tag    = rsp_valid ? w_rsp_head.tag : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= '0;
            r_err     <= 1'b0;
        end else begin
            case ({w_issue, w_rsp_pop})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
            if (alu_result_valid && w_tag_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_spurious = r_err;
endmodule

// File: doc/alu_addsub_dispatch.md
Name: alu_addsub_dispatch

Overview:
- Initiator side of the ALU add/sub operand interface.
- Accepts tagged operation requests from an upstream issue stage over a valid/ready handshake and buffers them in a request FIFO.
- Drives them into a multi-cycle W0RM_ALU_AddSub (no backpressure on its result side) and captures every result into a credit-protected response buffer.
- Returns results in order with their tags over a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, operand/result width
OPCODE_WIDTH, 4, ALU opcode width
FLAGS_WIDTH, 4, ALU result flag width
TAG_WIDTH, 4, request tag width, carried through unchanged
REQ_DEPTH, 4, request FIFO entries (power of 2, >=2)
MAX_INFLIGHT, 2, max ops issued but not yet popped at rsp side; also response buffer depth (power of 2, >=1)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request FIFO not full
req_opcode  in  OPCODE_WIDTH  operation
req_a  in  DATA_WIDTH  operand A
req_b  in  DATA_WIDTH  operand B
req_tag  in  TAG_WIDTH  caller tag
alu_data_valid  out  1  one-cycle issue strobe to ALU
alu_opcode  out  OPCODE_WIDTH  issued opcode
alu_data_a  out  DATA_WIDTH  issued operand A
alu_data_b  out  DATA_WIDTH  issued operand B
alu_result_valid  in  1  ALU result strobe
alu_result  in  DATA_WIDTH  ALU result
alu_result_flags  in  FLAGS_WIDTH  ALU flags
rsp_valid  out  1  response available
rsp_ready  in  1  downstream accepts
rsp_result  out  DATA_WIDTH  result
rsp_flags  out  FLAGS_WIDTH  flags
rsp_tag  out  TAG_WIDTH  tag of the op
err_spurious  out  1  sticky: ALU result arrived with nothing in flight

Behaviour:
- Reset (async, rst_n=0): FIFOs empty, credit counter 0, tag queue empty. Outputs: req_ready=0 during reset, 1 in the first cycle after release. alu_data_valid=0, alu_opcode/a/b=0, rsp_valid=0, rsp_result/flags/tag=0, err_spurious=0. Reset mid-operation discards all queued, in-flight and buffered work. ALU results arriving after reset are flagged as spurious.
- Request accept: req_valid & req_ready at cycle N writes {opcode,a,b,tag} into the request FIFO. req_ready = !req_full and does not depend on a same-cycle pop.
- Issue: when the request FIFO is non-empty and credits < MAX_INFLIGHT, pop the head. Register it onto alu_* with alu_data_valid=1 for exactly one cycle, push its tag into the tag queue, and increment credits. Earliest alu_data_valid for a request accepted at N is N+1. At most one issue per cycle, so back-to-back issue gives one per cycle. alu_opcode/a/b hold their last value when not issuing.
- Capture: alu_result_valid=1 pops the tag queue and writes {result,flags,tag} into the response buffer the same cycle. Credits guarantee the buffer never overflows.
- If alu_result_valid=1 while the tag queue is empty: set err_spurious (sticky until reset) and drop the result.
- Response: rsp_valid = response buffer non-empty. Data is the head entry and is stable while rsp_valid & !rsp_ready. A handshake pops the entry and decrements credits. Earliest rsp_valid is one cycle after capture.
- Simultaneous events:
  - issue + rsp pop in the same cycle leaves credits unchanged.
  - capture + pop on a full or single-entry buffer is legal.
  - request push + issue pop on the request FIFO in the same cycle is legal.
- Ordering: responses leave strictly in issue order, and issue order equals request order.

Optional Feature:
- Macro ALU_DISPATCH_BYPASS_EN.
- Defined: when the request FIFO is empty and a credit is free, an accepted request skips the FIFO and drives alu_* in the same cycle (combinational path from req_* to alu_*). Issue latency is 0, and the FIFO is not written.
- Undefined: alu_* outputs are fully registered, with issue latency >=1 as above.

Test Plan:
- Bench uses a stub ALU: fixed 2-cycle latency, result=a+b, flags={carry,3'b0}.
- Reset release, single req opcode=0, a=0x7F, b=0x01, tag=3 -> alu_data_valid pulses at N+1 with a=0x7F, b=0x01; rsp_valid with result=0x80, flags=0x0, tag=3; credits back to 0.
- Back-to-back 4 reqs (tags 0-3), rsp_ready=1 -> alu_data_valid on 2 consecutive cycles, then stalls until credits free; responses return tags 0,1,2,3 in order; no overflow.
- rsp_ready=0 with 6 reqs offered -> exactly 2 issued; req_ready drops after 4 FIFO entries; rsp data stable. Raise rsp_ready -> all 6 drain in order.
- a=0xFF, b=0x01 -> result=0x00, flags=0x8.
- Inject alu_result_valid with nothing issued -> err_spurious=1 and stays 1 until rst_n=0.
- Assert rst_n=0 with 2 in flight and 3 queued -> all outputs at reset values; late stub results set err_spurious. With ALU_DISPATCH_BYPASS_EN, a single req to an idle block gives alu_data_valid in the accept cycle.
